// File: rtl/quick_cpu_pkg.sv
// Shared definitions for the quick CPU: opcodes, execute FSM encoding, default memory latency.
package quick_cpu_pkg;

   localparam int DEFAULT_MEM_LAT = 1;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LDIH = 4'h2;
   localparam logic [3:0] OP_MOVB = 4'h3;
   localparam logic [3:0] OP_LD   = 4'h4;
   localparam logic [3:0] OP_ST   = 4'h5;
   localparam logic [3:0] OP_ADD  = 4'h6;
   localparam logic [3:0] OP_SUB  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_JZ   = 4'hC;
   localparam logic [3:0] OP_JC   = 4'hD;
   localparam logic [3:0] OP_OUT  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EXEC   = 3'd1,
      S_MEM_RD = 3'd2,
      S_MEM_WR = 3'd3,
      S_HALT   = 3'd4
   } state_t;

endpackage

// File: rtl/quick_cpu_alu.sv
// Two-operand ALU for ADD/SUB/AND/OR/XOR; other opcodes pass A through.
// Latency: combinational. Backpressure: none.
// carry_out is the 9th sum bit for ADD and the borrow for SUB, 0 otherwise.
module quick_cpu_alu
   import quick_cpu_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] opcode,
   output logic [7:0] result,
   output logic       carry_out,
   output logic       zero
);

   logic [8:0] wide;

   always_comb begin
      wide      = 9'd0;
      result    = a;
      carry_out = 1'b0;
      case (opcode)
         OP_ADD: begin
            wide      = {1'b0, a} + {1'b0, b};
            result    = wide[7:0];
            carry_out = wide[8];
         end
         OP_SUB: begin
            // borrow appears as the top bit of the 9-bit difference
            wide      = {1'b0, a} - {1'b0, b};
            result    = wide[7:0];
            carry_out = wide[8];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         default: result = a;
      endcase
      zero = (result == 8'h00);
   end

endmodule

// File: rtl/quick_cpu_exec.sv
// Execute stage: decodes one instruction per handshake, runs it on A/B/Z/C, drives the data bus.
// Latency: done 1 cycle after accept, 1+MEM_LAT for LD, 2 for ST.
// Backpressure: instr_ready only in IDLE; HALT holds it low until rst.
module quick_cpu_exec
   import quick_cpu_pkg::*;
#(
   parameter int         MEM_LAT = DEFAULT_MEM_LAT,
   parameter logic [7:0] RESET_B = 8'h01
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [7:0] instr,
   output logic       done,
   output logic       branch_taken,
   output logic [7:0] branch_target,
   output logic [7:0] mem_addr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic [7:0] out_data,
   output logic       halted,
   output logic [7:0] dbg_a,
   output logic [7:0] dbg_b
);

   localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

   state_t     state_q, state_d;
   logic [7:0] ir_q;
   logic [7:0] a_q, b_q;
   logic       z_q, c_q;
   logic [7:0] out_q;
   logic       halted_q;
   logic [7:0] tgt_q;
   logic [1:0] lat_cnt_q;

   logic [3:0] opcode;
   logic [3:0] imm;
   logic [7:0] ldih_val;
   logic       lat_last;
   logic       br_take;

   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_zero;

   assign opcode   = ir_q[7:4];
   assign imm      = ir_q[3:0];
   assign ldih_val = {imm, a_q[3:0]};
   assign lat_last = (lat_cnt_q == LAT_LAST);

   quick_cpu_alu u_alu (
      .a         (a_q),
      .b         (b_q),
      .opcode    (opcode),
      .result    (alu_result),
      .carry_out (alu_carry),
      .zero      (alu_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobes and pulses decode straight from state so an async reset kills them at once.
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      done        = 1'b0;
      br_take     = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = 8'h00;
      mem_wdata   = 8'h00;
      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_LD: state_d = S_MEM_RD;
               OP_ST: state_d = S_MEM_WR;
               OP_HALT: begin
                  done    = 1'b1;
                  state_d = S_HALT;
               end
               default: begin
                  done    = 1'b1;
                  state_d = S_IDLE;
                  br_take = (opcode == OP_JMP) ||
                            ((opcode == OP_JZ) && z_q) ||
                            ((opcode == OP_JC) && c_q);
               end
            endcase
         end
         S_MEM_RD: begin
            mem_rd   = 1'b1;
            mem_addr = b_q;
            if (lat_last) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_MEM_WR: begin
            mem_wr    = 1'b1;
            mem_addr  = b_q;
            mem_wdata = a_q;
            done      = 1'b1;
            state_d   = S_IDLE;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   assign branch_taken  = br_take;
   assign branch_target = br_take ? a_q : tgt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_q      <= 8'h00;
         a_q       <= 8'h00;
         b_q       <= RESET_B;
         z_q       <= 1'b0;
         c_q       <= 1'b0;
         out_q     <= 8'h00;
         halted_q  <= 1'b0;
         tgt_q     <= 8'h00;
         lat_cnt_q <= 2'd0;
      end else begin
         if ((state_q == S_IDLE) && instr_valid) begin
            ir_q <= instr;
         end

         if (state_q == S_EXEC) begin
            lat_cnt_q <= 2'd0;
         end else if (state_q == S_MEM_RD) begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
         end

         // branch_target holds the last taken target between branches
         if (br_take) begin
            tgt_q <= a_q;
         end

         if (state_q == S_EXEC) begin
            case (opcode)
               OP_LDI: begin
                  a_q <= {4'h0, imm};
                  z_q <= (imm == 4'h0);
               end
               OP_LDIH: begin
                  a_q <= ldih_val;
                  z_q <= (ldih_val == 8'h00);
               end
               OP_MOVB: b_q <= a_q;
               OP_ADD, OP_SUB: begin
                  a_q <= alu_result;
                  c_q <= alu_carry;
                  z_q <= alu_zero;
               end
               OP_AND, OP_OR, OP_XOR: begin
                  a_q <= alu_result;
                  z_q <= alu_zero;
               end
               OP_OUT:  out_q    <= a_q;
               OP_HALT: halted_q <= 1'b1;
               default: ;
            endcase
         end

         if ((state_q == S_MEM_RD) && lat_last) begin
            a_q <= mem_rdata;
            z_q <= (mem_rdata == 8'h00);
         end
      end
   end

   assign out_data = out_q;
   assign halted   = halted_q;
   assign dbg_a    = a_q;
   assign dbg_b    = b_q;

endmodule

// File: tb/tb_quick_cpu_exec.sv
// Scoreboard bench for quick_cpu_exec with MEM_LAT=2 and a byte-array data memory.
module tb_quick_cpu_exec;
   import quick_cpu_pkg::*;

   localparam int MEM_LAT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [7:0] instr = 8'h00;
   logic       done;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic       mem_wr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic [7:0] out_data;
   logic       halted;
   logic [7:0] dbg_a;
   logic [7:0] dbg_b;

   always #5 clk = ~clk;

   quick_cpu_exec #(.MEM_LAT(MEM_LAT), .RESET_B(8'h01)) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .done          (done),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .mem_addr      (mem_addr),
      .mem_rd        (mem_rd),
      .mem_wr        (mem_wr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .out_data      (out_data),
      .halted        (halted),
      .dbg_a         (dbg_a),
      .dbg_b         (dbg_b)
   );

   logic [7:0] mem [256] = '{default: 8'h00};
   logic       poke_vld = 1'b0;
   logic [7:0] poke_addr = 8'h00;
   logic [7:0] poke_dat = 8'h00;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_wr)
         mem[mem_addr] <= mem_wdata;
      else if (poke_vld)
         mem[poke_addr] <= poke_dat;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic       taken;
      logic [7:0] tgt;
      int         lat;
      logic       is_ld;
      logic       is_st;
      logic [7:0] maddr;
      logic [7:0] wdat;
   } exp_t;

   exp_t sbq[$];

   // architectural reference model
   logic [7:0] m_a, m_b, m_out, m_tgt;
   logic       m_z, m_c, m_halt;

   task automatic model_reset();
      m_a = 8'h00; m_b = 8'h01; m_out = 8'h00; m_tgt = 8'h00;
      m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
   endtask

   task automatic model(input logic [7:0] ins, output exp_t e);
      logic [3:0] op, imm;
      logic [8:0] s;
      op = ins[7:4];
      imm = ins[3:0];
      e.taken = 1'b0; e.lat = 1; e.is_ld = 1'b0; e.is_st = 1'b0;
      e.maddr = m_b; e.wdat = m_a;
      case (op)
         4'h1: begin m_a = {4'h0, imm}; m_z = (m_a == 8'h00); end
         4'h2: begin m_a = {imm, m_a[3:0]}; m_z = (m_a == 8'h00); end
         4'h3: m_b = m_a;
         4'h4: begin m_a = mem[m_b]; m_z = (m_a == 8'h00); e.lat = 1 + MEM_LAT; e.is_ld = 1'b1; end
         4'h5: begin e.lat = 2; e.is_st = 1'b1; end
         4'h6: begin s = 9'(m_a) + 9'(m_b); m_c = s[8]; m_a = s[7:0]; m_z = (m_a == 8'h00); end
         4'h7: begin m_c = (m_a < m_b); m_a = m_a - m_b; m_z = (m_a == 8'h00); end
         4'h8: begin m_a = m_a & m_b; m_z = (m_a == 8'h00); end
         4'h9: begin m_a = m_a | m_b; m_z = (m_a == 8'h00); end
         4'hA: begin m_a = m_a ^ m_b; m_z = (m_a == 8'h00); end
         4'hB: e.taken = 1'b1;
         4'hC: e.taken = m_z;
         4'hD: e.taken = m_c;
         4'hE: m_out = m_a;
         4'hF: m_halt = 1'b1;
         default: ;
      endcase
      if (e.taken) m_tgt = m_a;
      e.tgt = m_tgt;
   endtask

   // monitor: pops the scoreboard on every done and polices the bus every cycle
   int cyc = 0, acc_cyc = 0, rd_cycles = 0;
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst) begin
         chk("strobe_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
         if (!mem_rd && !mem_wr) chk("addr_idle", mem_addr, 8'h00);
         if (instr_valid && instr_ready) begin
            acc_cyc = cyc;
            rd_cycles = 0;
         end
         if (mem_rd) begin
            rd_cycles++;
            if (sbq.size() > 0) chk("rd_addr", mem_addr, sbq[0].maddr);
         end
         if (mem_wr && sbq.size() > 0) begin
            chk("wr_addr", mem_addr, sbq[0].maddr);
            chk("wr_data", mem_wdata, sbq[0].wdat);
            chk("wr_is_st", {31'd0, sbq[0].is_st}, 32'd1);
         end
         if (done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("latency", cyc - acc_cyc, e.lat);
               chk("br_taken", {31'd0, branch_taken}, {31'd0, e.taken});
               chk("br_target", branch_target, e.tgt);
               if (e.is_ld) chk("rd_cycles", rd_cycles, MEM_LAT);
            end
         end else begin
            chk("br_no_done", {31'd0, branch_taken}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [7:0] ins);
      exp_t e;
      int n;
      model(ins, e);
      sbq.push_back(e);
      @(posedge clk); #1;
      instr = ins;
      instr_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!instr_ready && n < 20);
      if (!instr_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 20);
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("dbg_a", dbg_a, m_a);
      chk("dbg_b", dbg_b, m_b);
      chk("out_data", out_data, m_out);
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      instr_valid = 1'b0;
      sbq.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_state();
      chk("rst_a", dbg_a, 8'h00);
      chk("rst_b", dbg_b, 8'h01);
      chk("rst_out", out_data, 8'h00);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_rd", {31'd0, mem_rd}, 32'd0);
      chk("rst_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_tgt", branch_target, 8'h00);
      chk("rst_wdata", mem_wdata, 8'h00);
   endtask

   logic [7:0] prog_a[] = '{8'h2A, 8'h15, 8'hE0,
                            8'h1F, 8'h30, 8'h2F, 8'h60, 8'h70, 8'hD0, 8'hC0,
                            8'h10, 8'h22, 8'h30, 8'h13, 8'h23, 8'h50};
   logic [7:0] prog_b[] = '{8'h40,
                            8'h10, 8'h24, 8'hB0, 8'h10, 8'hC0, 8'h60, 8'hD0,
                            8'hA0, 8'hC0, 8'h1C, 8'h90, 8'h80, 8'h00, 8'hF0};

   initial begin
      int n;
      model_reset();
      do_reset();
      check_reset_state();

      foreach (prog_a[i]) issue(prog_a[i]);

      // replace the stored byte so the load returns a distinct value
      @(posedge clk); #1;
      poke_addr = 8'h20; poke_dat = 8'h7C; poke_vld = 1'b1;
      @(posedge clk); #1;
      poke_vld = 1'b0;

      foreach (prog_b[i]) issue(prog_b[i]);

      // halted core must ignore a persistently offered instruction
      @(posedge clk); #1;
      instr = 8'h11;
      instr_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("halt_ready", {31'd0, instr_ready}, 32'd0);
      end
      chk("halt_sticky", {31'd0, halted}, 32'd1);
      instr_valid = 1'b0;

      do_reset();
      check_reset_state();

      // reset in the middle of a load: strobe drops at once, nothing retires
      @(posedge clk); #1;
      instr = 8'h40;
      instr_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_rd && n < 10);
      chk("midop_rd_seen", {31'd0, mem_rd}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midop_rd_drop", {31'd0, mem_rd}, 32'd0);
      chk("midop_done", {31'd0, done}, 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("midop_a", dbg_a, 8'h00);
      chk("midop_ready", {31'd0, instr_ready}, 32'd1);
      chk("midop_sbq", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/quick_cpu_exec.md
Name: quick_cpu_exec

Overview:
- Execute stage for the quick CPU. Sits directly downstream of the fetch sequencer, which drives pc, the micro-counter and the instruction latch.
- Accepts one fetched 8-bit instruction per handshake and decodes it. Executes it against registers A/B and flags Z/C.
- Performs data-memory loads/stores over the shared byte bus. Reports branch redirects and completion back to fetch.
- Instruction format: opcode = instr[7:4], imm4 = instr[3:0].

Parameters:
MEM_LAT, 1, cycles between asserting mem_rd and sampling mem_rdata; legal range 1..3.
RESET_B, 8'h01, reset value of register B.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
instr_valid  input  1  fetch presents a valid instruction
instr_ready  output  1  exec can accept an instruction (high only in IDLE)
instr  input  8  instruction byte
done  output  1  one-cycle pulse when the accepted instruction retires
branch_taken  output  1  one-cycle pulse, coincident with done, when fetch must load pc
branch_target  output  8  new pc; valid when branch_taken
mem_addr  output  8  data-memory address
mem_rd  output  1  read strobe
mem_wr  output  1  write strobe
mem_wdata  output  8  store data
mem_rdata  input  8  load data
out_data  output  8  output-port register
halted  output  1  sticky halt flag
dbg_a  output  8  register A
dbg_b  output  8  register B

Behaviour:
- Reset (async, rst=1): A=0, B=RESET_B, Z=0, C=0, out_data=0, halted=0, state=IDLE. All strobes and pulses 0; mem_addr=0, mem_wdata=0, branch_target=0.
- Reset mid-operation aborts the instruction and drops mem_rd/mem_wr in the same cycle; no retirement is reported.
- FSM states: IDLE, EXEC, MEM_RD, MEM_WR, HALT.
- IDLE: instr_ready=1. When instr_valid=1, latch instr and go to EXEC. When instr_valid=0, stay in IDLE.
- EXEC, register/ALU/branch ops: update state and pulse done this cycle, then return to IDLE. Latency from accept to done is 1 cycle, so back-to-back throughput is 1 instruction per 2 cycles.
- Opcodes:
  - 0 NOP.
  - 1 LDI: A={4'h0,imm4}.
  - 2 LDIH: A[7:4]=imm4, A[3:0] kept.
  - 3 MOVB: B=A.
  - 4 LD: A=mem[B].
  - 5 ST: mem[B]=A.
  - 6 ADD: {C,A}=A+B, 9-bit.
  - 7 SUB: A=A-B; C=1 on borrow (A<B unsigned).
  - 8 AND, 9 OR, A XOR: A=A op B; C unchanged.
  - B JMP: target=A.
  - C JZ: branch if Z.
  - D JC: branch if C.
  - E OUT: out_data=A.
  - F HALT.
- Flags:
  - Z is updated to (result==0) by ops 1, 2, 4, 6, 7, 8, 9, A. All other ops leave Z unchanged.
  - C is changed only by ADD and SUB. All arithmetic wraps modulo 256.
- LD:
  - EXEC goes to MEM_RD.
  - MEM_RD holds mem_rd=1 and mem_addr=B for exactly MEM_LAT cycles. On the last of those cycles, A is loaded from mem_rdata, Z is updated, done pulses, and the FSM returns to IDLE.
  - Total latency from accept to done is 1+MEM_LAT cycles.
- ST:
  - EXEC goes to MEM_WR.
  - MEM_WR drives mem_wr=1, mem_addr=B, mem_wdata=A for one cycle. done pulses in that same cycle, then IDLE.
  - mem_rd and mem_wr are never asserted together.
- Branches: when taken, branch_taken=1 and branch_target=A for one cycle, together with done. When not taken, done pulses alone and branch_target holds its last value.
- HALT: done pulses, halted=1, FSM enters HALT. In HALT, instr_ready=0 permanently; only rst exits.
- instr_valid while not ready is ignored (not queued); fetch must hold the instruction until accepted.
- mem_addr returns to 0 when no strobe is active.

Decomposition:
- Shared package quick_cpu_pkg holds:
  - opcode constants OP_NOP..OP_HALT (4-bit);
  - FSM state encoding;
  - the default MEM_LAT.
- The fetch sequencer also imports this package.
- One natural sub-module: quick_cpu_alu. It is combinational: inputs A, B, opcode; outputs result[7:0], carry_out, zero. The FSM and register file stay in quick_cpu_exec.

Test Plan:
- Reset then idle:
  - rst pulse -> dbg_a=0, dbg_b=1, out_data=0, halted=0, instr_ready=1, no strobes.
- Immediates and output:
  - Sequence 0x2A (LDIH) -> A=0xA0.
  - Then 0x15 (LDI) -> A=0x05, Z=0.
  - Then 0xE0 (OUT) -> out_data=0x05.
  - done pulses 1 cycle after each accept.
- Arithmetic wrap and flags:
  - Setup: LDI 0x0F; MOVB (B=0x0F); LDIH 0xF (A=0xFF).
  - ADD -> A=0x0E, C=1, Z=0.
  - Then SUB -> A=0xFF, C=1 (0x0E<0x0F), Z=0.
- Load/store with MEM_LAT=2:
  - Setup: B=0x20, A=0x33.
  - ST -> one cycle mem_wr=1, mem_addr=0x20, mem_wdata=0x33.
  - LD with memory model returning 0x7C -> mem_rd high exactly 2 cycles at addr 0x20, A=0x7C, done 3 cycles after accept.
- Branches:
  - Setup: A=0x40.
  - JMP -> branch_taken pulse with target 0x40.
  - LDI 0 (Z=1), then JZ -> taken, target 0x00.
  - With C=0, JC -> done without branch_taken.
- Halt and reset mid-op:
  - HALT -> halted=1, instr_ready stays 0 for 10 cycles despite instr_valid=1.
  - Separately, assert rst during MEM_RD of an LD -> mem_rd drops immediately, A keeps its reset value, no done pulse.
